// File: rtl/ft_pkg.sv
// Shared types and default constants for the lockstep data-port guard.
package ft_pkg;

  localparam int SKEW_MAX_DEF = 2;
  localparam int TIMEOUT_DEF  = 16;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RESP,
    FAULT
  } ft_guard_state_e;

  // Field order matches the concatenation {we, be, addr, wdata}.
  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } ft_data_req_t;

endpackage

// File: rtl/ft_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module ft_sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so every
  // flop samples the pre-edge value of every other flop regardless of block order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) count_q <= '0;
    else         count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/ft_data_guard.sv
// Lockstep guard: forwards a data access to memory only when both cores agree
// within a bounded skew; any disagreement blocks the access and raises a fault.
module ft_data_guard
  import ft_pkg::*;
#(
  parameter int SKEW_MAX = SKEW_MAX_DEF,
  parameter int TIMEOUT  = TIMEOUT_DEF,
  parameter int CNT_W    = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             data_req_a_i,
  input  logic             data_req_b_i,
  input  logic             data_we_a_i,
  input  logic             data_we_b_i,
  input  logic [3:0]       data_be_a_i,
  input  logic [3:0]       data_be_b_i,
  input  logic [31:0]      data_addr_a_i,
  input  logic [31:0]      data_addr_b_i,
  input  logic [31:0]      data_wdata_a_i,
  input  logic [31:0]      data_wdata_b_i,
  output logic             data_gnt_o,
  output logic             data_rvalid_o,
  output logic [31:0]      data_rdata_o,
  output logic             data_err_o,
  output logic             data_req_o,
  output logic             data_we_o,
  output logic [3:0]       data_be_o,
  output logic [31:0]      data_addr_o,
  output logic [31:0]      data_wdata_o,
  input  logic             data_gnt_i,
  input  logic             data_rvalid_i,
  input  logic [31:0]      data_rdata_i,
  input  logic             data_err_i,
  input  logic             clear_i,
  output logic             mismatch_o,
  output logic             fault_o,
  output logic [CNT_W-1:0] mismatch_cnt_o
);

  localparam int SKEW_W = $clog2(SKEW_MAX + 1);
  localparam int TO_W   = $clog2(TIMEOUT + 1);

  ft_guard_state_e state_d, state_q;
  ft_data_req_t    capt_d, capt_q;
  ft_data_req_t    req_a, req_b;
  logic            mismatch_d, mismatch_q;
  logic            skew_inc, skew_clr, to_inc, to_clr, mm_inc;
  logic [SKEW_W-1:0] skew_cnt;
  logic [TO_W-1:0]   to_cnt;

  assign req_a = {data_we_a_i, data_be_a_i, data_addr_a_i, data_wdata_a_i};
  assign req_b = {data_we_b_i, data_be_b_i, data_addr_b_i, data_wdata_b_i};

  // NOTE: every signal written here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    state_d       = state_q;
    capt_d        = capt_q;
    mismatch_d    = 1'b0;
    skew_inc      = 1'b0;
    skew_clr      = 1'b0;
    to_inc        = 1'b0;
    to_clr        = 1'b0;
    mm_inc        = 1'b0;
    data_req_o    = 1'b0;
    data_we_o     = 1'b0;
    data_be_o     = '0;
    data_addr_o   = '0;
    data_wdata_o  = '0;
    data_gnt_o    = 1'b0;
    data_rvalid_o = 1'b0;
    data_rdata_o  = '0;
    data_err_o    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (data_req_a_i && data_req_b_i) begin
          // Covers the late request landing on the skew-expiry cycle as well.
          skew_clr = 1'b1;
          if (req_a == req_b) begin
            capt_d  = req_a;
            state_d = ISSUE;
          end else begin
            state_d = FAULT;
          end
        end else if (data_req_a_i || data_req_b_i) begin
          if (skew_cnt >= SKEW_W'(SKEW_MAX)) state_d = FAULT;
          else                               skew_inc = 1'b1;
        end else begin
          skew_clr = 1'b1;
        end
        if (state_d == FAULT) begin
          mismatch_d = 1'b1;
          mm_inc     = 1'b1;
        end
      end
      ISSUE: begin
        data_req_o   = 1'b1;
        data_we_o    = capt_q.we;
        data_be_o    = capt_q.be;
        data_addr_o  = capt_q.addr;
        data_wdata_o = capt_q.wdata;
        data_gnt_o   = data_gnt_i;
        if (data_gnt_i) begin
          to_clr  = 1'b1;
          state_d = WAIT_RESP;
        end
      end
      WAIT_RESP: begin
        // A real response wins over a timeout landing in the same cycle.
        if (data_rvalid_i) begin
          data_rvalid_o = 1'b1;
          data_rdata_o  = data_rdata_i;
          data_err_o    = data_err_i;
          state_d       = IDLE;
        end else if (to_cnt >= TO_W'(TIMEOUT)) begin
          data_rvalid_o = 1'b1;
          data_err_o    = 1'b1;
          state_d       = IDLE;
        end else begin
          to_inc = 1'b1;
        end
      end
      FAULT: begin
        skew_clr = 1'b1;
        if (clear_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the capture register is reset too, so the memory-side fields are
  // deterministic from the first cycle out of reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      capt_q     <= '0;
      mismatch_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      capt_q     <= capt_d;
      mismatch_q <= mismatch_d;
    end
  end

  assign mismatch_o = mismatch_q;
  assign fault_o    = (state_q == FAULT);

  ft_sat_counter #(.WIDTH(SKEW_W)) u_skew_cnt (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (skew_clr),
    .inc_i   (skew_inc),
    .count_o (skew_cnt)
  );

  ft_sat_counter #(.WIDTH(TO_W)) u_timeout_cnt (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (to_clr),
    .inc_i   (to_inc),
    .count_o (to_cnt)
  );

  ft_sat_counter #(.WIDTH(CNT_W)) u_mismatch_cnt (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (1'b0),
    .inc_i   (mm_inc),
    .count_o (mismatch_cnt_o)
  );

endmodule
